// File: rtl/rv32im_dmem_ctrl.sv
// rv32im_dmem_ctrl: LSU-to-bus data-memory controller with lane steering and response timeout.
// Define RV32IM_DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses without a bus transaction.
module rv32im_dmem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_en_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  misalign_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic we_q, we_d, breq_q, breq_d, bwe_q, bwe_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0] be_q, be_d, be_acc;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wdata_acc, rdata_q, rdata_d;
    assign be_acc = !we_i ? 4'hf :
                    size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
                    size_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'hf;
    assign wdata_acc = size_i == 2'b00 ? {4{wdata_i[7:0]}} :
                       size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
    logic mis_q, mis_d, mis_acc;
    assign mis_acc = size_i == 2'b01 ? addr_i[0] : size_i[1] & (addr_i[1:0] != 2'b00);
    assign misalign_o = mis_q;
`else
    assign misalign_o = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        breq_d  = breq_q;
        bwe_d   = bwe_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: if (req_en_i) begin
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
                if (mis_acc) begin
                    state_d = DONE;
                    mis_d   = 1'b1;
                end else
`endif
                begin
                    state_d = REQ;
                    we_d    = we_i;
                    breq_d  = 1'b1;
                    bwe_d   = we_i;
                    addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = be_acc;
                    wdata_d = wdata_acc;
                end
            end
            REQ: if (bus_gnt_i) begin
                state_d = RESP;
                cnt_d   = '0;
                breq_d  = 1'b0;
                bwe_d   = 1'b0;
                be_d    = '0;
                wdata_d = '0;
            end
            RESP: if (bus_rvalid_i) begin
                state_d = DONE;
                rdata_d = we_q ? '0 : bus_rdata_i;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = DONE;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
                mis_d   = 1'b0;
`endif
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            breq_q  <= 1'b0;
            bwe_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            breq_q  <= breq_d;
            bwe_q   <= bwe_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef RV32IM_DMEM_MISALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end
    assign stall_o     = req_en_i & (state_q != DONE);
    assign done_o      = state_q == DONE;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign bus_req_o   = breq_q;
    assign bus_we_o    = bwe_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
endmodule
